// File: rtl/idct_dot_acc_stage.sv
// ============================================================================
// Module   : idct_dot_acc_stage
// Purpose  : Aligns and accumulates DOT_LEN multiplier products into one
//            rounded, narrowed IDCT dot-product result, emitted with valid/ready.
//            Optional output clamping: define ACC_SATURATE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module idct_dot_acc_stage #(
  parameter int DOT_LEN      = 8,
  parameter int ACC_BITWIDTH = 40,
  parameter int FRAC_SHIFT   = 8,
  parameter int OUT_BITWIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rstN,
  input  logic                    clr,
  input  logic [31:0]             p_in,
  input  logic [2:0]              state_in,
  input  logic                    p_valid,
  output logic                    p_ready,
  output logic [OUT_BITWIDTH-1:0] sum_out,
  output logic                    sum_valid,
  input  logic                    sum_ready,
  output logic [5:0]              sum_idx,
  output logic                    last,
  output logic                    ovf_flag
);

  localparam int c_cnt_w = (DOT_LEN > 1) ? $clog2(DOT_LEN) : 1;
  localparam int c_rw    = ACC_BITWIDTH + 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DOT_LEN - 1);

  // HOLD means the output register carries a result not yet taken.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic signed [ACC_BITWIDTH-1:0] acc_q, acc_d;
  logic [c_cnt_w-1:0]        cnt_q, cnt_d;
  logic [OUT_BITWIDTH-1:0]   sum_q, sum_d;
  logic [5:0]                idx_q, idx_d;
  logic                      ovf_q, ovf_d;

  logic signed [ACC_BITWIDTH-1:0] w_ext, w_addend, w_acc_sum;
  logic signed [c_rw-1:0]    w_rnd_in, w_r;
  logic [c_rw-1:0]           w_round;
  logic [OUT_BITWIDTH-1:0]   w_narrow;
  logic                      w_ovf, w_accept, w_drain, w_load;

  // State 3'b010 carries 8 extra fraction bits from the multiplier wrapper.
  assign w_ext     = {{(ACC_BITWIDTH-32){p_in[31]}}, p_in};
  assign w_addend  = (state_in == 3'b010) ? (w_ext >>> 8) : w_ext;
  assign w_acc_sum = (cnt_q == '0) ? w_addend : (acc_q + w_addend);

  generate
    if (FRAC_SHIFT > 0) begin : g_round
      assign w_round = c_rw'(1) << (FRAC_SHIFT - 1);
    end else begin : g_no_round
      assign w_round = '0;
    end
  endgenerate

  assign w_rnd_in = {w_acc_sum[ACC_BITWIDTH-1], w_acc_sum} + w_round;
  assign w_r      = w_rnd_in >>> FRAC_SHIFT;

`ifdef ACC_SATURATE_EN
  logic [c_rw-OUT_BITWIDTH:0] w_hi;
  logic                       w_pos, w_neg;
  assign w_hi     = w_r[c_rw-1:OUT_BITWIDTH-1];
  assign w_pos    = !w_r[c_rw-1] && (|w_hi);
  assign w_neg    = w_r[c_rw-1] && !(&w_hi);
  assign w_ovf    = w_pos || w_neg;
  assign w_narrow = w_pos ? {1'b0, {(OUT_BITWIDTH-1){1'b1}}} :
                    w_neg ? {1'b1, {(OUT_BITWIDTH-1){1'b0}}} :
                            w_r[OUT_BITWIDTH-1:0];
`else
  logic w_unused;
  assign w_unused = ^w_r[c_rw-1:OUT_BITWIDTH];
  assign w_ovf    = 1'b0;
  assign w_narrow = w_r[OUT_BITWIDTH-1:0];
`endif

  assign sum_valid = (state_q == S_HOLD);
  assign p_ready   = !((cnt_q == c_last) && sum_valid && !sum_ready);
  assign sum_out   = sum_q;
  assign sum_idx   = idx_q;
  assign last      = sum_valid && (idx_q == 6'd63);
  assign ovf_flag  = ovf_q;

  assign w_accept = p_valid && p_ready && !clr;
  assign w_drain  = sum_valid && sum_ready;
  assign w_load   = w_accept && (cnt_q == c_last);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    if (clr) begin
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      sum_d   = '0;
      idx_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      if (w_accept) begin
        cnt_d = w_load ? '0 : cnt_q + 1'b1;
        acc_d = w_load ? '0 : w_acc_sum;
      end
      if (w_load) begin
        sum_d = w_narrow;
        ovf_d = ovf_q | w_ovf;
      end
      if (w_drain) begin
        idx_d = idx_q + 6'd1;
      end
      case (state_q)
        S_IDLE: if (w_accept) state_d = S_ACC;
        S_ACC:  if (w_load)   state_d = S_HOLD;
        S_HOLD: begin
          if (w_load)       state_d = S_HOLD;
          else if (w_drain) state_d = (cnt_d != '0) ? S_ACC : S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_idct_dot_acc_stage.sv
// ============================================================================
// Module   : tb_idct_dot_acc_stage
// Purpose  : Directed self-checking bench for idct_dot_acc_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_idct_dot_acc_stage;

  logic        clk = 1'b0;
  logic        rstN = 1'b1;
  logic        clr = 1'b0;
  logic [31:0] p_in = '0;
  logic [2:0]  state_in = '0;
  logic        p_valid = 1'b0;
  logic        sum_ready = 1'b1;
  logic        p_ready, sum_valid, last, ovf_flag;
  logic [15:0] sum_out;
  logic [5:0]  sum_idx;

  int n_tests = 0;
  int n_fail  = 0;
  logic [5:0] exp_idx;

  idct_dot_acc_stage dut (
    .clk       (clk),
    .rstN      (rstN),
    .clr       (clr),
    .p_in      (p_in),
    .state_in  (state_in),
    .p_valid   (p_valid),
    .p_ready   (p_ready),
    .sum_out   (sum_out),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .sum_idx   (sum_idx),
    .last      (last),
    .ovf_flag  (ovf_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents one product from a negedge and returns at the accepting posedge.
  task automatic put(input logic [31:0] p, input logic [2:0] st);
    @(negedge clk);
    p_in = p; state_in = st; p_valid = 1'b1;
    for (int n = 0; !p_ready; n++) begin
      if (n == 20) begin
        check("p_ready_timeout", 32'd0, 32'd1);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
  endtask

  task automatic dot(input logic [31:0] first, input logic [31:0] rest, input logic [2:0] st);
    put(first, st);
    for (int i = 1; i < 8; i++) put(rest, st);
    @(negedge clk);
    p_valid = 1'b0;
  endtask

  task automatic check_res(input string tag, input logic [15:0] val, input logic [5:0] idx);
    check({tag, "_valid"}, {31'd0, sum_valid}, 32'd1);
    check({tag, "_out"},   {16'd0, sum_out},   {16'd0, val});
    check({tag, "_idx"},   {26'd0, sum_idx},   {26'd0, idx});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    #2 rstN = 1'b0;
    #1;
    check("rst_valid", {31'd0, sum_valid}, 32'd0);
    check("rst_out",   {16'd0, sum_out},   32'd0);
    check("rst_idx",   {26'd0, sum_idx},   32'd0);
    check("rst_ovf",   {31'd0, ovf_flag},  32'd0);
    check("rst_ready", {31'd0, p_ready},   32'd1);
    @(negedge clk) rstN = 1'b1;

    // 1: k<<8, k=1..8 -> 36
    for (int k = 1; k < 8; k++) put(32'(k) << 8, 3'b011);
    @(negedge clk);
    p_valid = 1'b0;
    check("t1_early_valid", {31'd0, sum_valid}, 32'd0);
    put(32'd8 << 8, 3'b011);
    @(negedge clk);
    p_valid = 1'b0;
    check_res("t1", 16'd36, 6'd0);

    // 2: aligned state, 0x10000>>>8 = 0x100 each -> 8
    dot(32'h0001_0000, 32'h0001_0000, 3'b010);
    check_res("t2", 16'd8, 6'd1);

    // 3: round half up
    dot(32'h0000_0180, 32'd0, 3'b011);
    check_res("t3_pos", 16'd2, 6'd2);
    dot(-32'sh180, 32'd0, 3'b011);
    check_res("t3_neg", 16'hFFFF, 6'd3);

    // 4: overflow
    dot(32'h7FFF_0000, 32'h7FFF_0000, 3'b011);
`ifdef ACC_SATURATE_EN
    check_res("t4", 16'h7FFF, 6'd4);
    check("t4_ovf", {31'd0, ovf_flag}, 32'd1);
`else
    check_res("t4", 16'hF800, 6'd4);
    check("t4_ovf", {31'd0, ovf_flag}, 32'd0);
`endif

    // 5: backpressure
    @(negedge clk);
    sum_ready = 1'b0;
    dot(32'd1 << 8, 32'd1 << 8, 3'b011);
    check_res("t5_a", 16'd8, 6'd5);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      p_in = 32'd2 << 8; state_in = 3'b011; p_valid = 1'b1;
      check("t5_ready_nonfinal", {31'd0, p_ready}, 32'd1);
      @(posedge clk);
    end
    @(negedge clk);
    p_in = 32'd2 << 8;
    check("t5_ready_final", {31'd0, p_ready}, 32'd0);
    repeat (2) @(negedge clk);
    check("t5_ready_stall", {31'd0, p_ready}, 32'd0);
    check_res("t5_held", 16'd8, 6'd5);
    sum_ready = 1'b1;
    #1 check("t5_ready_release", {31'd0, p_ready}, 32'd1);
    @(negedge clk);
    p_valid = 1'b0;
    sum_ready = 1'b0;
    check_res("t5_b", 16'd16, 6'd6);
    @(negedge clk);
    sum_ready = 1'b1;
    @(negedge clk);
    check("t5_drained", {31'd0, sum_valid}, 32'd0);
    check("t5_idx", {26'd0, sum_idx}, 32'd7);

    // 6: index wrap across 64 dots
    exp_idx = 6'd7;
    for (int d = 0; d < 64; d++) begin
      dot(32'(d + 1) << 8, 32'(d + 1) << 8, 3'b011);
      check_res("t6", 16'(8 * (d + 1)), exp_idx);
      check("t6_last", {31'd0, last}, {31'd0, exp_idx == 6'd63});
      exp_idx = exp_idx + 6'd1;
    end

    // reset mid-dot
    for (int i = 0; i < 3; i++) put(32'd5 << 8, 3'b011);
    @(negedge clk);
    p_valid = 1'b0;
    rstN = 1'b0;
    #1;
    check("t6r_valid", {31'd0, sum_valid}, 32'd0);
    check("t6r_out",   {16'd0, sum_out},   32'd0);
    check("t6r_idx",   {26'd0, sum_idx},   32'd0);
    check("t6r_last",  {31'd0, last},      32'd0);
    check("t6r_ovf",   {31'd0, ovf_flag},  32'd0);
    check("t6r_ready", {31'd0, p_ready},   32'd1);
    @(negedge clk) rstN = 1'b1;
    dot(32'd3 << 8, 32'd3 << 8, 3'b011);
    check_res("t6r_clean", 16'd24, 6'd0);

    // synchronous clear mid-dot, with a product presented alongside it
    for (int i = 0; i < 3; i++) put(32'd9 << 8, 3'b011);
    @(negedge clk);
    clr = 1'b1; p_in = 32'd100 << 8; p_valid = 1'b1;
    @(negedge clk);
    clr = 1'b0; p_valid = 1'b0;
    check("clr_valid", {31'd0, sum_valid}, 32'd0);
    check("clr_out",   {16'd0, sum_out},   32'd0);
    check("clr_idx",   {26'd0, sum_idx},   32'd0);
    dot(32'd1 << 8, 32'd1 << 8, 3'b011);
    check_res("clr_clean", 16'd8, 6'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
